// File: rtl/cdc_handshake_fsm_1clk_if.sv
// Valid/ready source and destination ports of the req/ack transfer block.
// The block takes the slave view; the producer/consumer side takes master.
interface cdc_handshake_fsm_1clk_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] src_data_i;
    logic                  src_valid_i;
    logic                  src_ready_o;
    logic [DATA_WIDTH-1:0] dst_data_o;
    logic                  dst_valid_o;
    logic                  dst_ready_i;

    modport master (
        output src_data_i, src_valid_i, dst_ready_i,
        input  src_ready_o, dst_data_o, dst_valid_o
    );

    modport slave (
        input  src_data_i, src_valid_i, dst_ready_i,
        output src_ready_o, dst_data_o, dst_valid_o
    );
endinterface

// File: rtl/cdc_handshake_fsm_1clk.sv
// Four-phase req/ack single-word transfer between a valid/ready source and
// destination, single-clock variant.
//
// state          | meaning
// S_IDLE         | source ready, waiting for src_valid
// S_WAIT_ACK_HI  | req raised, data_q held, waiting for synced ack high
// S_WAIT_ACK_LO  | req dropped, waiting for synced ack low
// D_IDLE         | waiting for synced req high
// D_VALID        | word presented on dst port until consumer takes it
// D_WAIT_REQ_LO  | ack raised, waiting for synced req low
module cdc_handshake_fsm_1clk #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    cdc_handshake_fsm_1clk_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_ACK_HI = 2'd1,
        S_WAIT_ACK_LO = 2'd2
    } src_state_t;

    typedef enum logic [1:0] {
        D_IDLE        = 2'd0,
        D_VALID       = 2'd1,
        D_WAIT_REQ_LO = 2'd2
    } dst_state_t;

    src_state_t src_state, src_next;
    dst_state_t dst_state, dst_next;

    logic                   req_q, ack_q;
    logic                   req_next, ack_next;
    logic [SYNC_STAGES-1:0] req_sync_q, ack_sync_q;
    logic                   req_sync, ack_sync;
    logic [DATA_WIDTH-1:0]  data_q, dst_data_q;
    logic                   load_src, load_dst;

    assign req_sync = req_sync_q[SYNC_STAGES-1];
    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    // req/ack leave the domain straight from flops so the sync chains never see a glitch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_state  <= S_IDLE;
            dst_state  <= D_IDLE;
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            req_sync_q <= '0;
            ack_sync_q <= '0;
            data_q     <= '0;
            dst_data_q <= '0;
        end else begin
            src_state  <= src_next;
            dst_state  <= dst_next;
            req_q      <= req_next;
            ack_q      <= ack_next;
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
            if (load_src) data_q     <= bus.src_data_i;
            if (load_dst) dst_data_q <= data_q;
        end
    end

    always_comb begin
        src_next = src_state;
        case (src_state)
            S_IDLE:        if (bus.src_valid_i) src_next = S_WAIT_ACK_HI;
            S_WAIT_ACK_HI: if (ack_sync)        src_next = S_WAIT_ACK_LO;
            S_WAIT_ACK_LO: if (!ack_sync)       src_next = S_IDLE;
            default:                            src_next = S_IDLE;
        endcase

        dst_next = dst_state;
        case (dst_state)
            D_IDLE:        if (req_sync)        dst_next = D_VALID;
            D_VALID:       if (bus.dst_ready_i) dst_next = D_WAIT_REQ_LO;
            D_WAIT_REQ_LO: if (!req_sync)       dst_next = D_IDLE;
            default:                            dst_next = D_IDLE;
        endcase
    end

    always_comb begin
        req_next        = (src_next == S_WAIT_ACK_HI);
        ack_next        = (dst_next == D_WAIT_REQ_LO);
        load_src        = (src_state == S_IDLE) && bus.src_valid_i;
        load_dst        = (dst_state == D_IDLE) && req_sync;
        bus.src_ready_o = (src_state == S_IDLE) && !rst_i;
        bus.dst_valid_o = (dst_state == D_VALID);
        bus.dst_data_o  = dst_data_q;
    end
endmodule

// File: tb/tb_cdc_handshake_fsm_1clk.sv
// Directed bench for cdc_handshake_fsm_1clk with a delivery scoreboard.
module tb_cdc_handshake_fsm_1clk;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [31:0] sb[$];
    int          del_cyc[$];
    int          acc_cyc;

    cdc_handshake_fsm_1clk_if #(.DATA_WIDTH(32)) bus ();

    cdc_handshake_fsm_1clk #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; the monitor looks 2ns later at what the next rising edge will see.
    always begin
        @(negedge clk);
        #2;
        if (!rst && bus.dst_valid_o && bus.dst_ready_i) begin
            chk("sb_nonempty_on_delivery", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("delivered_data", 64'(bus.dst_data_o), 64'(sb.pop_front()));
            del_cyc.push_back(cyc);
        end
    end

    // Offer a word and return at the falling edge right after its accept edge.
    task automatic send(input logic [31:0] d, input bit expect_delivery);
        bus.src_valid_i = 1'b1;
        bus.src_data_i  = d;
        for (int i = 0; i < 200 && !bus.src_ready_o; i++) @(negedge clk);
        chk("accept_ready", 64'(bus.src_ready_o), 64'd1);
        if (expect_delivery) sb.push_back(d);
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
        for (int i = 0; i < 80 && !bus.src_ready_o; i++) @(negedge clk);
        chk({tag, "_src_ready_back"}, 64'(bus.src_ready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0;
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = '0;
        bus.dst_ready_i = 1'b0;

        // reset held for 3 cycles
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_src_ready", 64'(bus.src_ready_o), 64'd0);
            chk("rst_dst_valid", 64'(bus.dst_valid_o), 64'd0);
            chk("rst_dst_data",  64'(bus.dst_data_o),  64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle_src_ready", 64'(bus.src_ready_o), 64'd1);
        chk("idle_dst_valid", 64'(bus.dst_valid_o), 64'd0);

        // single word, edge-by-edge timing
        bus.dst_ready_i = 1'b1;
        send(32'h0000_0001, 1'b1);
        bus.src_valid_i = 1'b0;
        chk("single_e0_src_ready", 64'(bus.src_ready_o), 64'd0);
        chk("single_e0_dst_valid", 64'(bus.dst_valid_o), 64'd0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("single_e%0d_dst_valid", k), 64'(bus.dst_valid_o), 64'(k == 3));
            chk($sformatf("single_e%0d_src_ready", k), 64'(bus.src_ready_o), 64'(k == 13));
            if (k == 3) chk("single_e3_dst_data", 64'(bus.dst_data_o), 64'h1);
        end
        drain("single");

        // backpressure for 20 cycles
        bus.dst_ready_i = 1'b0;
        send(32'h1234_5678, 1'b1);
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("bp_src_ready", 64'(bus.src_ready_o), 64'd0);
            chk("bp_dst_valid", 64'(bus.dst_valid_o), 64'(k >= 3));
            if (k >= 3) chk("bp_dst_data_hold", 64'(bus.dst_data_o), 64'h1234_5678);
        end
        bus.dst_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_dst_valid_after_hs", 64'(bus.dst_valid_o), 64'd0);
        drain("bp");

        // back-to-back with src_valid held high
        del_cyc.delete();
        send(32'h1234_5678, 1'b1);
        a0 = acc_cyc;
        send(32'h123D_EFEF, 1'b1);
        chk("b2b_accept_spacing", 64'(acc_cyc - a0), 64'd14);
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 32'h0;
        drain("b2b");
        chk("b2b_delivery_count", 64'(del_cyc.size()), 64'd2);
        if (del_cyc.size() == 2) begin
            d0 = del_cyc[0];
            chk("b2b_delivery_spacing", 64'(del_cyc[1] - d0), 64'd14);
            chk("b2b_latency", 64'(d0 - a0), 64'd3);
        end

        // source data changes right after accept
        send(32'hABCD_EFEF, 1'b1);
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 32'hFFFF_FFFF;
        drain("srcchg");

        // reset at E2 drops the in-flight word
        send(32'hDEAD_BEEF, 1'b0);
        bus.src_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dst_valid", 64'(bus.dst_valid_o), 64'd0);
        chk("midrst_src_ready", 64'(bus.src_ready_o), 64'd0);
        chk("midrst_dst_data",  64'(bus.dst_data_o),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("midrst_no_delivery", 64'(bus.dst_valid_o), 64'd0);
        end
        chk("midrst_src_ready_after", 64'(bus.src_ready_o), 64'd1);
        send(32'h0000_0005, 1'b1);
        bus.src_valid_i = 1'b0;
        drain("post_rst");

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
